// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit for the EX stage; owns HI/LO.
// Results are computed at accept time, held as pending, and committed to
// HI/LO on the edge where the busy counter reaches zero.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        start,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] out
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } op_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0]      cnt;
    logic [31:0]        pend_hi, pend_lo;
    logic               pend_wr;

    logic               is_mult, is_div;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        div_b;
    logic signed [31:0] q_s, r_s;
    logic [31:0]        q_u, r_u;
    logic [31:0]        nxt_hi, nxt_lo;
    logic               nxt_wr;

    assign is_mult = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);
    assign busy    = (cnt != '0);
    assign start   = en && !busy && (is_mult || is_div);

    // Arithmetic datapath and pending-result selection for the current request.
    always_comb begin
        nxt_hi = '0;
        nxt_lo = '0;
        nxt_wr = 1'b0;
        prod_s = 64'($signed(A)) * 64'($signed(B));
        prod_u = {32'd0, A} * {32'd0, B};
        // Substitute a divisor of 1 on divide-by-zero; the result is never committed.
        div_b  = (B == '0) ? 32'd1 : B;
        // Most-negative / -1 overflows a 32-bit quotient; pin it to the defined result.
        if (A == 32'h8000_0000 && B == '1) begin
            q_s = $signed(A);
            r_s = '0;
        end else begin
            q_s = $signed(A) / $signed(div_b);
            r_s = $signed(A) % $signed(div_b);
        end
        q_u = A / div_b;
        r_u = A % div_b;
        case (op)
            OP_MULT: begin
                {nxt_hi, nxt_lo} = prod_s;
                nxt_wr = 1'b1;
            end
            OP_MULTU: begin
                {nxt_hi, nxt_lo} = prod_u;
                nxt_wr = 1'b1;
            end
            OP_DIV: begin
                nxt_hi = r_s;
                nxt_lo = q_s;
                nxt_wr = (B != '0);
            end
            OP_DIVU: begin
                nxt_hi = r_u;
                nxt_lo = q_u;
                nxt_wr = (B != '0);
            end
            default: ;
        endcase
    end

    // mfhi/mflo read the architectural registers directly, no forwarding.
    always_comb begin
        case (op)
            OP_MFHI: out = HI;
            OP_MFLO: out = LO;
            default: out = '0;
        endcase
    end

    // Accept, busy countdown with commit on 1->0, and single-cycle mthi/mtlo.
    always_ff @(posedge clk) begin
        if (reset) begin
            HI      <= '0;
            LO      <= '0;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && pend_wr) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
        end else if (start) begin
            pend_hi <= nxt_hi;
            pend_lo <= nxt_lo;
            pend_wr <= nxt_wr;
            cnt     <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (en && op == OP_MTHI) begin
            HI <= A;
        end else if (en && op == OP_MTLO) begin
            LO <= A;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: expected {HI,LO} pushed at issue,
// popped and compared when busy falls.
module tb_mdu_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  op;
    logic [31:0] A, B;
    logic        busy, start;
    logic [31:0] HI, LO, out;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .A(A), .B(B),
        .busy(busy), .start(start), .HI(HI), .LO(LO), .out(out)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: returns {HI,LO} after the operation commits.
    function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] ch,
                                            input logic [31:0] cl);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            4'd1: begin
                q = sa * sb;
                p = q;
                return p;
            end
            4'd2: begin
                p = 64'(a) * 64'(b);
                return p;
            end
            4'd3: begin
                if (b == 32'd0) return {ch, cl};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {ch, cl};
                return {a % b, a / b};
            end
            default: return {ch, cl};
        endcase
    endfunction

    // Issue one mult/div, count busy cycles, then check committed HI/LO.
    task automatic run_md(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        logic [63:0] e;
        en = 1'b1; op = o; A = a; B = b;
        #1;
        chk({tag, "_start"}, 32'(start), 32'd1);
        exp_q.push_back(ref_res(o, a, b, m_hi, m_lo));
        tick();
        en = 1'b0; op = 4'd0; A = $urandom; B = $urandom;
        n = 0;
        while (busy && n < 100) begin
            chk({tag, "_hold_hi"}, HI, m_hi);
            chk({tag, "_hold_lo"}, LO, m_lo);
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(n), (o <= 4'd2) ? 32'(MC) : 32'(DC));
        e = exp_q.pop_front();
        m_hi = e[63:32];
        m_lo = e[31:0];
        chk({tag, "_hi"}, HI, m_hi);
        chk({tag, "_lo"}, LO, m_lo);
    endtask

    task automatic run_mt(input string tag, input logic [3:0] o, input logic [31:0] a);
        en = 1'b1; op = o; A = a; B = '0;
        tick();
        en = 1'b0; op = 4'd0;
        if (o == 4'd7) m_hi = a; else m_lo = a;
        chk({tag, "_hi"}, HI, m_hi);
        chk({tag, "_lo"}, LO, m_lo);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Main stimulus sequence.
    initial begin
        int n;
        logic [63:0] e;
        logic [3:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1; en = 1'b0; op = 4'd0; A = '0; B = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_out", out, 32'd0);

        // Requests during busy (including at the commit edge) are ignored.
        en = 1'b1; op = 4'd1; A = 32'd2; B = 32'd3;
        #1;
        chk("ign_start", 32'(start), 32'd1);
        exp_q.push_back(ref_res(4'd1, 32'd2, 32'd3, m_hi, m_lo));
        tick();
        en = 1'b0; op = 4'd0;
        n = 0;
        while (busy && n < 100) begin
            case (n)
                1: begin en = 1'b0; op = 4'd6; end
                2: begin en = 1'b1; op = 4'd8; A = 32'h55; end
                3: begin en = 1'b1; op = 4'd4; A = 32'd9; B = 32'd2; end
                4: begin en = 1'b1; op = 4'd7; A = 32'hdead; end
                default: begin en = 1'b0; op = 4'd0; end
            endcase
            #1;
            chk("ign_start_busy", 32'(start), 32'd0);
            if (n == 1) chk("ign_out_precommit", out, m_lo);
            n++;
            tick();
        end
        en = 1'b0; op = 4'd0;
        chk("ign_busy_cycles", 32'(n), 32'(MC));
        e = exp_q.pop_front();
        m_hi = e[63:32]; m_lo = e[31:0];
        chk("ign_hi", HI, m_hi);
        chk("ign_lo", LO, m_lo);
        chk("ign_lo_6", LO, 32'd6);
        tick(); tick();
        chk("ign_idle_hi", HI, m_hi);
        chk("ign_idle_busy", 32'(busy), 32'd0);

        // Directed arithmetic cases.
        run_md("mult_neg", 4'd1, 32'hFFFF_FFFD, 32'd5);
        chk("mult_neg_hi_k", HI, 32'hFFFF_FFFF);
        chk("mult_neg_lo_k", LO, 32'hFFFF_FFF1);
        run_md("multu", 4'd2, 32'hFFFF_FFFF, 32'd2);
        chk("multu_hi_k", HI, 32'h0000_0001);
        run_md("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_lo_k", LO, 32'hFFFF_FFFD);
        chk("div_neg_hi_k", HI, 32'hFFFF_FFFF);

        // Divide by zero leaves preloaded HI/LO intact.
        run_mt("mthi", 4'd7, 32'h11);
        run_mt("mtlo", 4'd8, 32'h22);
        run_md("divu_zero", 4'd4, 32'd7, 32'd0);
        op = 4'd5; #1;
        chk("mfhi_out", out, 32'h11);
        op = 4'd6; #1;
        chk("mflo_out", out, 32'h22);
        op = 4'd0; #1;
        chk("none_out", out, 32'd0);

        run_md("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo_k", LO, 32'h8000_0000);
        chk("div_ovf_hi_k", HI, 32'd0);

        // Random mix.
        for (int i = 0; i < 8; i++) begin
            ro = 4'(1 + $urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            run_md("rand", ro, ra, rb);
        end

        // Reset during busy discards the in-flight divide.
        en = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
        #1;
        exp_q.push_back(ref_res(4'd3, 32'd100, 32'd7, m_hi, m_lo));
        tick();
        en = 1'b0; op = 4'd0;
        tick(); tick(); tick();
        chk("rst_mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(exp_q.pop_front());
        m_hi = '0; m_lo = '0;
        chk("rst_mid_busy_after", 32'(busy), 32'd0);
        chk("rst_mid_hi", HI, m_hi);
        chk("rst_mid_lo", LO, m_lo);
        repeat (12) tick();
        chk("rst_mid_late_hi", HI, m_hi);
        chk("rst_mid_late_lo", LO, m_lo);
        chk("rst_mid_late_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers.
- Drives the 32-bit MDU result that the E/M pipeline register captures as MDUOut_E.
- Exports busy so the hazard unit can stall dependent mult/div/mf*/mt* instructions in E.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
en  input  1  E-stage instruction valid for MDU (0 when E is flushed/bubble)
op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none
A  input  32  rs operand (forwarded)
B  input  32  rt operand (forwarded)
busy  output  1  operation in progress
start  output  1  combinational: en & ~busy & op in {1..4}
HI  output  32  HI register
LO  output  32  LO register
out  output  32  combinational: HI if op=5, LO if op=6, else 0

Behaviour:
- Reset is synchronous and active-high on clk; there is no initial block dependence. On reset:
  - HI=0, LO=0, busy=0, counter=0, pending results=0.
  - Any in-flight operation is discarded and does not commit.
- Accept edge: at a clk edge where start=1, the unit latches the pending result computed from A/B at that edge, loads counter with MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4), and sets busy=1. A/B may change afterwards.
- Busy period:
  - busy = (counter != 0).
  - counter decrements on each edge while nonzero.
  - On the edge where counter goes 1->0, HI/LO take the pending values and busy falls.
  - busy is therefore high for exactly N cycles after the accept edge, and the new HI/LO are visible in the first cycle with busy=0.
- mult: {HI,LO} = signed(A)*signed(B), 64-bit.
- multu: {HI,LO} = unsigned 64-bit product.
- div:
  - LO = signed quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = A/B, HI = A%B, unsigned.
- Divide by zero (B=0, div or divu): the operation is accepted and busy runs the full DIV_CYCLES, but HI/LO are left unchanged at commit.
- mthi / mtlo: at an edge with en=1, busy=0 and op=7 or 8, HI<=A (op 7) or LO<=A (op 8). Single-cycle, no busy.
- mfhi / mflo: out reflects the current HI/LO registers combinationally, with no internal forwarding of same-cycle writes.
- While busy=1:
  - All en/op requests (start, mthi, mtlo) are ignored with no side effects.
  - out still reads the current, pre-commit HI/LO.
  - The hazard unit must stall op 1..8 in E whenever (busy | start).
- Commit edge with en=1 and op in {1..8}: busy is still 1 at that edge, so the request is ignored. The pipeline holds it via stall and re-presents it in the next cycle.
- en=0 or op=none: no state change.

Test Plan:
- mult, A=0xFFFFFFFD (-3), B=5, one-cycle en -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; HI/LO unchanged while busy.
- multu, A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE. Then div, A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, A=7, B=0, with HI=0x11, LO=0x22 preloaded via mthi/mtlo -> busy 10 cycles; HI=0x11, LO=0x22 after commit. op=5 -> out=0x11; op=6 -> out=0x22.
- div, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start mult (A=2, B=3); two cycles later present mtlo A=0x55 and a divu, both with en=1 -> both ignored; final LO=6, HI=0, busy low after 5 cycles.
- Start div (A=100, B=7); assert reset on the 4th busy cycle -> next cycle busy=0, HI=0, LO=0; no later commit occurs.
